// File: rtl/cc_select_encoder.sv
// Round-robin encoder for the active-low register request bus: arbitrates g0..IR,
// offers the winner's index on a valid/ready handshake and returns an active-low one-hot grant.
module cc_select_encoder #(
    parameter int DATAWIDTH_ENCODER_SELECTION = 4,
    parameter int DATAWIDTH_ENCODER_IN        = 16,
    parameter int NUM_SOURCES                 = 14
) (
    input  logic                                   CC_ENCODER_CLOCK_50,
    input  logic                                   CC_ENCODER_RESET_InLow,
    input  logic [DATAWIDTH_ENCODER_IN-1:0]        CC_ENCODER_Request_InBUS,
    input  logic                                   CC_ENCODER_Ready_In,
    output logic                                   CC_ENCODER_Valid_Out,
    output logic [DATAWIDTH_ENCODER_SELECTION-1:0] CC_ENCODER_Selection_OutBUS,
    output logic [DATAWIDTH_ENCODER_IN-1:0]        CC_ENCODER_Grant_OutBUS,
    output logic                                   CC_ENCODER_Error_Out
);

    localparam int SEL_W  = DATAWIDTH_ENCODER_SELECTION;
    localparam int IN_W   = DATAWIDTH_ENCODER_IN;
    localparam int CAND_W = SEL_W + 1;
    localparam logic [SEL_W-1:0] PTR_RESET = SEL_W'(NUM_SOURCES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   ptr_d;
    logic               valid_q;
    logic               valid_d;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_d;
    logic [IN_W-1:0]    grant_q;
    logic [IN_W-1:0]    grant_d;
    logic               error_q;
    logic               error_d;

    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic [CAND_W-1:0]  cand;
    logic [IN_W-1:0]    grant_onehot;
    logic               transfer;

    // Search starts just after the last transfer winner and wraps over the legal lines only.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_SOURCES; off++) begin
            cand = {1'b0, ptr_q} + CAND_W'(off);
            if (cand >= CAND_W'(NUM_SOURCES)) begin
                cand = cand - CAND_W'(NUM_SOURCES);
            end
            if (!win_found && !CC_ENCODER_Request_InBUS[cand[SEL_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        error_d = 1'b0;
        for (int i = NUM_SOURCES; i < IN_W; i++) begin
            if (!CC_ENCODER_Request_InBUS[i]) begin
                error_d = 1'b1;
            end
        end
    end

    assign grant_onehot = ~(IN_W'(1) << win_idx);
    assign transfer     = valid_q && CC_ENCODER_Ready_In;

    always_ff @(posedge CC_ENCODER_CLOCK_50) begin
        if (!CC_ENCODER_RESET_InLow) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_RESET;
            valid_q <= 1'b0;
            sel_q   <= '0;
            grant_q <= '1;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (transfer) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // The offer is frozen until accepted; requests are not resampled while offering.
    always_comb begin
        valid_d = valid_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    valid_d = 1'b1;
                    sel_d   = win_idx;
                    grant_d = grant_onehot;
                end else begin
                    valid_d = 1'b0;
                    grant_d = '1;
                end
            end
            ST_OFFER: begin
                if (transfer) begin
                    valid_d = 1'b0;
                    grant_d = '1;
                    ptr_d   = sel_q;
                end
            end
        endcase
    end

    assign CC_ENCODER_Valid_Out        = valid_q;
    assign CC_ENCODER_Selection_OutBUS = sel_q;
    assign CC_ENCODER_Grant_OutBUS     = grant_q;
    assign CC_ENCODER_Error_Out        = error_q;

endmodule
